// File: rtl/ucode_sequencer_if.sv
// Bus bundle between the microcode sequencer and its EPROM, control-store RAM
// and micro-op decode/branch logic.
interface ucode_sequencer_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int WORD_WIDTH = 64
);
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [WORD_WIDTH-1:0] rom_data;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [WORD_WIDTH-1:0] ram_wdata;
   logic                  ram_we;
   logic                  cs_ready;
   logic [ADDR_WIDTH-1:0] upc;
   logic                  stall;
   logic                  jump;
   logic                  call;
   logic                  ret;
   logic [ADDR_WIDTH-1:0] target;
   logic                  stack_err;

   modport master (
      output rom_addr, ram_addr, ram_wdata, ram_we, cs_ready, upc, stack_err,
      input  rom_data, stall, jump, call, ret, target
   );

   modport slave (
      input  rom_addr, ram_addr, ram_wdata, ram_we, cs_ready, upc, stack_err,
      output rom_data, stall, jump, call, ret, target
   );
endinterface

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: boot-copies the EPROM image into control-store RAM, then
// steps the micro-PC. Optional call/return stack is enabled with UCODE_STACK_EN.
module ucode_sequencer #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WORD_WIDTH  = 64,
   parameter int STACK_DEPTH = 4
) (
   input logic              clk,
   input logic              reset,
   ucode_sequencer_if.master bus
);
   typedef enum logic [0:0] {ST_COPY = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

   state_t                state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0] copy_addr_r, copy_addr_nxt_s;
   logic [ADDR_WIDTH-1:0] upc_r, upc_nxt_s, upc_inc_s;
   logic                  stack_err_r, stack_err_nxt_s;

   assign upc_inc_s = upc_r + ADDR_ONE;

`ifdef UCODE_STACK_EN
   localparam int SP_W = $clog2(STACK_DEPTH + 1);
   localparam logic [SP_W-1:0] SP_ZERO = {SP_W{1'b0}};
   localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   // Entry 0 is always top-of-stack; push/pop shift the whole array.
   logic [ADDR_WIDTH-1:0] stack_r [STACK_DEPTH];
   logic [SP_W-1:0]       sp_r, sp_nxt_s;
   logic                  push_s, pop_s;
`else
   logic unused_cfg_s;
   assign unused_cfg_s = bus.ret & (STACK_DEPTH != 0);
`endif

   // Next-state, copy address, micro-PC and stack decisions.
   always_comb begin
      state_nxt_s     = state_r;
      copy_addr_nxt_s = copy_addr_r;
      upc_nxt_s       = upc_r;
      stack_err_nxt_s = stack_err_r;
`ifdef UCODE_STACK_EN
      sp_nxt_s        = sp_r;
      push_s          = 1'b0;
      pop_s           = 1'b0;
`endif
      case (state_r)
         ST_COPY: begin
            copy_addr_nxt_s = copy_addr_r + ADDR_ONE;
            if (copy_addr_r == ADDR_LAST) begin
               state_nxt_s = ST_RUN;
               upc_nxt_s   = ADDR_ZERO;
            end else begin
               state_nxt_s = ST_COPY;
            end
         end
         ST_RUN: begin
            if (bus.stall) begin
               upc_nxt_s = upc_r;
`ifdef UCODE_STACK_EN
            end else if (bus.ret) begin
               if (sp_r != SP_ZERO) begin
                  upc_nxt_s = stack_r[0];
                  pop_s     = 1'b1;
                  sp_nxt_s  = sp_r - SP_ONE;
               end else begin
                  upc_nxt_s       = upc_inc_s;
                  stack_err_nxt_s = 1'b1;
               end
            end else if (bus.call) begin
               // Overflowing call still jumps; only the return address is lost.
               upc_nxt_s = bus.target;
               if (sp_r != SP_FULL) begin
                  push_s   = 1'b1;
                  sp_nxt_s = sp_r + SP_ONE;
               end else begin
                  stack_err_nxt_s = 1'b1;
               end
`else
            end else if (bus.call) begin
               upc_nxt_s = bus.target;
`endif
            end else if (bus.jump) begin
               upc_nxt_s = bus.target;
            end else begin
               upc_nxt_s = upc_inc_s;
            end
         end
         default: begin
            state_nxt_s     = ST_COPY;
            copy_addr_nxt_s = ADDR_ZERO;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_COPY;
         copy_addr_r <= ADDR_ZERO;
         upc_r       <= ADDR_ZERO;
         stack_err_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         copy_addr_r <= copy_addr_nxt_s;
         upc_r       <= upc_nxt_s;
         stack_err_r <= stack_err_nxt_s;
      end
   end

`ifdef UCODE_STACK_EN
   // Stack pointer and shift-register stack storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         sp_r <= SP_ZERO;
      end else begin
         sp_r <= sp_nxt_s;
         if (push_s) begin
            stack_r[0] <= upc_inc_s;
            for (int i = 1; i < STACK_DEPTH; i++) stack_r[i] <= stack_r[i-1];
         end else if (pop_s) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) stack_r[i] <= stack_r[i+1];
         end else begin
            stack_r <= stack_r;
         end
      end
   end
`endif

   // Memory-side outputs; write enable is gated by reset so no write lands while it is held.
   always_comb begin
      if (state_r == ST_RUN) begin
         bus.rom_addr  = upc_r;
         bus.ram_addr  = upc_r;
         bus.ram_wdata = {WORD_WIDTH{1'b0}};
         bus.ram_we    = 1'b0;
      end else begin
         bus.rom_addr  = copy_addr_r;
         bus.ram_addr  = copy_addr_r;
         bus.ram_wdata = bus.rom_data;
         bus.ram_we    = ~reset;
      end
   end

   assign bus.cs_ready  = (state_r == ST_RUN);
   assign bus.upc       = upc_r;
   assign bus.stack_err = stack_err_r;
endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer (ADDR_WIDTH=4): vector table, hand-written
// reset/stack corner cases and randomized run-mode stimulus against a reference model.
module tb_ucode_sequencer;
   localparam int AW = 4;
   localparam int WW = 16;
   localparam int SD = 2;
   localparam int NW = 1 << AW;
`ifdef UCODE_STACK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ucode_sequencer_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

   ucode_sequencer #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .STACK_DEPTH(SD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // EPROM image: word n = n * 0x0101
   assign bus.rom_data = WW'(bus.rom_addr) * 16'h0101;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit s, j, c, r;
      int t;
      int eu;
      bit ee;
   } vec_t;
   vec_t tbl[$];

   int m_upc;
   int m_stk[$];
   bit m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl(input bit s, input bit j, input bit c, input bit r, input int t);
      bus.stall  = s;
      bus.jump   = j;
      bus.call   = c;
      bus.ret    = r;
      bus.target = AW'(t);
   endtask

   function automatic void add(input bit s, input bit j, input bit c, input bit r,
                               input int t, input int eu, input bit ee);
      vec_t v;
      v.s = s; v.j = j; v.c = c; v.r = r; v.t = t; v.eu = eu; v.ee = ee;
      tbl.push_back(v);
   endfunction

   // Behavioural model of one run-mode step.
   function automatic void model_step(input bit s, input bit j, input bit c, input bit r, input int t);
      if (s) return;
      if (STK && r) begin
         if (m_stk.size() > 0) m_upc = m_stk.pop_back();
         else begin m_err = 1'b1; m_upc = (m_upc + 1) % NW; end
      end else if (c || j) begin
         if (STK && c) begin
            if (m_stk.size() < SD) m_stk.push_back((m_upc + 1) % NW);
            else m_err = 1'b1;
         end
         m_upc = t;
      end else begin
         m_upc = (m_upc + 1) % NW;
      end
   endfunction

   task automatic copy_phase(input bit check_each);
      for (int k = 0; k < NW; k++) begin
         if (check_each) begin
            chk("copy_we", 32'(bus.ram_we), 32'd1);
            chk("copy_addr", 32'(bus.ram_addr), 32'(k));
            chk("copy_data", 32'(bus.ram_wdata), 32'(k * 16'h0101));
            chk("copy_notready", 32'(bus.cs_ready), 32'd0);
         end
         tick();
      end
      chk("ready_after_copy", 32'(bus.cs_ready), 32'd1);
      chk("upc_after_copy", 32'(bus.upc), 32'd0);
      chk("we_in_run", 32'(bus.ram_we), 32'd0);
   endtask

   initial begin
      int e;
      ctl(1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Vector table, starting from upc=0 right after the boot copy.
      for (int i = 1; i < NW; i++) add(0, 0, 0, 0, 0, i, 0);
      add(0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 2, 0);
      add(1, 1, 0, 0, 9, 2, 0);
      add(0, 1, 0, 0, 9, 9, 0);
      add(0, 1, 0, 0, 5, 5, 0);
      add(1, 0, 0, 0, 0, 5, 0);
      add(1, 0, 0, 0, 0, 5, 0);
      add(1, 0, 0, 0, 0, 5, 0);
      add(0, 0, 0, 0, 0, 6, 0);
      add(0, 1, 0, 0, 3, 3, 0);
      add(0, 0, 1, 0, 'hA, 'hA, 0);
      add(0, 0, 1, 0, 'hC, 'hC, 0);
      add(0, 0, 0, 1, 0, STK ? 'hB : 'hD, 0);
      add(0, 0, 0, 1, 0, STK ? 4 : 'hE, 0);
      add(0, 0, 1, 0, 1, 1, 0);
      add(0, 0, 1, 0, 2, 2, 0);
      add(0, 0, 1, 0, 3, 3, STK);
      add(0, 0, 0, 1, 0, STK ? 2 : 4, STK);
      add(0, 0, 0, 1, 0, 5, STK);
      add(0, 0, 0, 1, 0, 6, STK);

      // Reset and boot copy.
      tick();
      tick();
      chk("rst_ready", 32'(bus.cs_ready), 32'd0);
      chk("rst_we", 32'(bus.ram_we), 32'd0);
      chk("rst_upc", 32'(bus.upc), 32'd0);
      chk("rst_err", 32'(bus.stack_err), 32'd0);
      reset = 1'b0;
      #1;
      copy_phase(1'b1);

      foreach (tbl[i]) begin
         ctl(tbl[i].s, tbl[i].j, tbl[i].c, tbl[i].r, tbl[i].t);
         tick();
         chk($sformatf("tbl_upc[%0d]", i), 32'(bus.upc), 32'(tbl[i].eu));
         chk($sformatf("tbl_err[%0d]", i), 32'(bus.stack_err), 32'(tbl[i].ee));
      end
      ctl(1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Reset mid-run, then reset again at copy address 6.
      reset = 1'b1;
      tick();
      chk("mr_ready", 32'(bus.cs_ready), 32'd0);
      chk("mr_upc", 32'(bus.upc), 32'd0);
      chk("mr_err", 32'(bus.stack_err), 32'd0);
      chk("mr_we", 32'(bus.ram_we), 32'd0);
      reset = 1'b0;
      #1;
      chk("mr_restart_addr", 32'(bus.ram_addr), 32'd0);
      chk("mr_restart_we", 32'(bus.ram_we), 32'd1);
      for (int k = 0; k < 6; k++) tick();
      chk("mc_addr6", 32'(bus.ram_addr), 32'd6);
      reset = 1'b1;
      #1;
      chk("mc_we_forced", 32'(bus.ram_we), 32'd0);
      tick();
      chk("mc_ready", 32'(bus.cs_ready), 32'd0);
      chk("mc_addr0", 32'(bus.ram_addr), 32'd0);
      reset = 1'b0;
      #1;
      copy_phase(1'b1);

      // Return on an empty stack.
      ctl(1'b0, 1'b1, 1'b0, 1'b0, 7);
      tick();
      chk("er_upc7", 32'(bus.upc), 32'd7);
      ctl(1'b0, 1'b0, 1'b0, 1'b1, 0);
      tick();
      chk("er_upc8", 32'(bus.upc), 32'd8);
      chk("er_err", 32'(bus.stack_err), 32'(STK));
      ctl(1'b0, 1'b0, 1'b0, 1'b0, 0);
      tick();
      tick();
      chk("er_upc10", 32'(bus.upc), 32'd10);
      chk("er_sticky", 32'(bus.stack_err), 32'(STK));

      // Randomized run mode from a fresh boot.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      copy_phase(1'b0);
      m_upc = 0;
      m_stk.delete();
      m_err = 1'b0;
      for (int n = 0; n < 400; n++) begin
         bit s, j, c, r;
         int t;
         s = ($urandom_range(0, 5) == 0);
         j = ($urandom_range(0, 4) == 0);
         c = ($urandom_range(0, 4) == 0);
         r = ($urandom_range(0, 4) == 0);
         t = $urandom_range(0, NW - 1);
         ctl(s, j, c, r, t);
         model_step(s, j, c, r, t);
         tick();
         chk($sformatf("rnd_upc[%0d]", n), 32'(bus.upc), 32'(m_upc));
         chk($sformatf("rnd_err[%0d]", n), 32'(bus.stack_err), 32'(m_err));
         chk($sformatf("rnd_ready[%0d]", n), 32'(bus.cs_ready), 32'd1);
      end
      e = fails;
      $display("[TB] %0d tests run, %0d failed", tests, e);
      $finish;
   end
endmodule
